// File: rtl/ripple_count_capture_if.sv
// Capture request / settled-count handshake between a consumer and ripple_count_capture.
interface ripple_count_capture_if;
  logic       capture_req;
  logic       out_ready;
  logic [3:0] count_out;
  logic       count_valid;

  modport master (
    output capture_req,
    output out_ready,
    input  count_out,
    input  count_valid
  );

  modport slave (
    input  capture_req,
    input  out_ready,
    output count_out,
    output count_valid
  );
endinterface

// File: rtl/ripple_count_capture.sv
// Synchronises an asynchronous 4-bit ripple counter, accepts only settled values,
// tallies 15->0 wraps and hands out one settled count per request.
module ripple_count_capture #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 3,
  parameter int unsigned TIMEOUT       = 16,
  parameter int unsigned WRAP_W        = 8
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [3:0]                ripple_in,
  ripple_count_capture_if.slave     bus,
  output logic                      wrap_pulse,
  output logic [WRAP_W-1:0]         wrap_count,
  output logic                      glitch_err
);

  localparam int unsigned STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WAIT_STABLE, HOLD} state_e;

  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0]                  s_q, s_d;
  logic [STAB_W-1:0]           stab_q, stab_d;
  logic [3:0]                  acc_q;
  logic [TMO_W-1:0]            tmo_q;
  state_e                      state_q;
  logic                        stable, accept, wrap_hit;

  // s_d is the value s will take on this edge, so stab_q counts cycles s_q has held
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], ripple_in};
  assign s_q      = sync_q[SYNC_STAGES-1];
  assign s_d      = sync_q[SYNC_STAGES-2];
  assign stable   = (stab_q == STAB_W'(STABLE_CYCLES));
  assign accept   = stable && (s_q != acc_q);
  assign wrap_hit = accept && (s_q < acc_q);

  always_comb begin
    stab_d = STAB_W'(1);
    if (s_d == s_q) begin
      stab_d = stable ? stab_q : stab_q + STAB_W'(1);
    end
  end

  // Synchroniser, stability filter, accepted value and wrap tally
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      stab_q     <= '0;
      acc_q      <= '0;
      wrap_pulse <= 1'b0;
      wrap_count <= '0;
    end else begin
      sync_q     <= sync_d;
      stab_q     <= stab_d;
      wrap_pulse <= wrap_hit;
      if (accept) begin
        acc_q <= s_q;
      end
      if (wrap_hit && (wrap_count != '1)) begin
        wrap_count <= wrap_count + WRAP_W'(1);
      end
    end
  end

  // Capture FSM; requests outside IDLE are dropped
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      tmo_q           <= '0;
      bus.count_out   <= '0;
      bus.count_valid <= 1'b0;
      glitch_err      <= 1'b0;
    end else begin
      glitch_err <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.capture_req) begin
            state_q <= WAIT_STABLE;
            tmo_q   <= '0;
          end
        end
        WAIT_STABLE: begin
          if (stable) begin
            bus.count_out   <= s_q;
            bus.count_valid <= 1'b1;
            state_q         <= HOLD;
          end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
            glitch_err <= 1'b1;
            state_q    <= IDLE;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end
        HOLD: begin
          if (bus.count_valid && bus.out_ready) begin
            bus.count_valid <= 1'b0;
            state_q         <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed bench for ripple_count_capture: capture handshake, wrap tally, glitch timeout,
// intermediate-state filtering, wrap saturation and asynchronous reset.
module tb_ripple_count_capture;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] ripple1, ripple2;
  logic       wrap_pulse1, wrap_pulse2, glitch1, glitch2;
  logic [7:0] wrap_count1;
  logic [1:0] wrap_count2;

  int total = 0;
  int bad   = 0;
  int wp1   = 0;
  int wp2   = 0;
  int gl1   = 0;
  logic [3:0] exp_q[$];

  ripple_count_capture_if ifc1 ();
  ripple_count_capture_if ifc2 ();

  ripple_count_capture #(.WRAP_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .ripple_in(ripple1), .bus(ifc1),
    .wrap_pulse(wrap_pulse1), .wrap_count(wrap_count1), .glitch_err(glitch1)
  );

  ripple_count_capture #(.WRAP_W(2)) dut_sat (
    .clk(clk), .reset_n(reset_n), .ripple_in(ripple2), .bus(ifc2),
    .wrap_pulse(wrap_pulse2), .wrap_count(wrap_count2), .glitch_err(glitch2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wrap_pulse1) wp1++;
    if (wrap_pulse2) wp2++;
    if (glitch1)     gl1++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Request a capture, check it lands within 2 cycles, hold it, then accept it.
  task automatic do_capture(input logic [3:0] exp, input int hold);
    int n;
    logic [3:0] want;
    exp_q.push_back(exp);
    ifc1.capture_req = 1'b1;
    tick();
    ifc1.capture_req = 1'b0;
    n = 1;
    while (!ifc1.count_valid && n < 6) begin
      tick();
      n++;
    end
    want = exp_q.pop_front();
    chk("cap_valid", 32'(ifc1.count_valid), 32'(1));
    chk("cap_latency_le2", 32'(n <= 2), 32'(1));
    chk("cap_value", 32'(ifc1.count_out), 32'(want));
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(ifc1.count_valid), 32'(1));
      chk("hold_value", 32'(ifc1.count_out), 32'(want));
    end
    ifc1.out_ready = 1'b1;
    tick();
    ifc1.out_ready = 1'b0;
    chk("release_valid", 32'(ifc1.count_valid), 32'(0));
  endtask

  initial begin
    int glitch_at;
    int valid_seen;
    logic [3:0] want;

    reset_n          = 1'b0;
    ripple1          = 4'd0;
    ripple2          = 4'd0;
    ifc1.capture_req = 1'b0;
    ifc1.out_ready   = 1'b0;
    ifc2.capture_req = 1'b0;
    ifc2.out_ready   = 1'b0;
    #3;
    chk("rst_valid", 32'(ifc1.count_valid), 32'(0));
    chk("rst_count_out", 32'(ifc1.count_out), 32'(0));
    chk("rst_wrap_count", 32'(wrap_count1), 32'(0));
    chk("rst_wrap_pulse", 32'(wrap_pulse1), 32'(0));
    chk("rst_glitch", 32'(glitch1), 32'(0));
    tick();
    tick();
    reset_n = 1'b1;

    // Sweep 0..15 then 0: every value captured, one wrap on 15->0
    for (int k = 0; k <= 16; k++) begin
      ripple1 = 4'(k % 16);
      repeat (6) tick();
      do_capture(4'(k % 16), 0);
      if (k == 15) chk("sweep_no_wrap_yet", 32'(wrap_count1), 32'(0));
    end
    repeat (2) tick();
    chk("sweep_wrap_count", 32'(wrap_count1), 32'(1));
    chk("sweep_wrap_pulses", 32'(wp1), 32'(1));

    // Steady 6, capture at cycle 10, held 10 cycles with out_ready low
    ripple1 = 4'd6;
    repeat (10) tick();
    do_capture(4'd6, 10);

    // 7/8 toggling every clock: no capture, glitch_err 16 cycles after entry
    for (int i = 0; i < 6; i++) begin
      ripple1 = (ripple1 == 4'd7) ? 4'd8 : 4'd7;
      tick();
    end
    glitch_at  = 0;
    valid_seen = 0;
    gl1        = 0;
    ifc1.capture_req = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      ifc1.capture_req = 1'b0;
      ripple1 = (ripple1 == 4'd7) ? 4'd8 : 4'd7;
      if (glitch1 && glitch_at == 0) glitch_at = i;
      if (ifc1.count_valid) valid_seen = 1;
    end
    chk("glitch_time", 32'(glitch_at), 32'(17));
    chk("glitch_once", 32'(gl1), 32'(1));
    chk("glitch_no_valid", 32'(valid_seen), 32'(0));

    // 7 -> 6 -> 4 -> 0 -> 8 with one-clock intermediates: only 7 and 8 accepted
    ripple1 = 4'd7;
    repeat (6) tick();
    do_capture(4'd7, 0);
    ripple1 = 4'd6; tick();
    ripple1 = 4'd4; tick();
    ripple1 = 4'd0; tick();
    ripple1 = 4'd8;
    repeat (6) tick();
    do_capture(4'd8, 0);
    chk("ripple_no_wrap_count", 32'(wrap_count1), 32'(1));
    chk("ripple_no_wrap_pulse", 32'(wp1), 32'(1));

    // Request during HOLD is dropped
    exp_q.push_back(4'd8);
    ifc1.capture_req = 1'b1;
    tick();
    ifc1.capture_req = 1'b0;
    tick();
    want = exp_q.pop_front();
    chk("hold_cap_valid", 32'(ifc1.count_valid), 32'(1));
    chk("hold_cap_value", 32'(ifc1.count_out), 32'(want));
    ifc1.capture_req = 1'b1;
    tick();
    ifc1.capture_req = 1'b0;
    tick();
    ifc1.out_ready = 1'b1;
    tick();
    ifc1.out_ready = 1'b0;
    valid_seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (ifc1.count_valid) valid_seen = 1;
      tick();
    end
    chk("no_second_capture", 32'(valid_seen), 32'(0));

    // Asynchronous reset while holding a valid count
    ifc1.capture_req = 1'b1;
    tick();
    ifc1.capture_req = 1'b0;
    tick();
    chk("pre_reset_valid", 32'(ifc1.count_valid), 32'(1));
    #2;
    reset_n = 1'b0;
    #1;
    chk("areset_valid", 32'(ifc1.count_valid), 32'(0));
    chk("areset_count_out", 32'(ifc1.count_out), 32'(0));
    chk("areset_wrap_count", 32'(wrap_count1), 32'(0));
    chk("areset_wrap_pulse", 32'(wrap_pulse1), 32'(0));
    chk("areset_glitch", 32'(glitch1), 32'(0));
    tick();
    reset_n = 1'b1;
    tick();

    // WRAP_W=2 instance: five wraps, tally saturates at 3
    wp2 = 0;
    for (int s = 0; s < 5; s++) begin
      for (int k = 1; k <= 16; k++) begin
        ripple2 = 4'(k % 16);
        repeat (6) tick();
      end
      if (s == 1) chk("sat_after_two", 32'(wrap_count2), 32'(2));
    end
    repeat (2) tick();
    chk("sat_wrap_count", 32'(wrap_count2), 32'(3));
    chk("sat_wrap_pulses", 32'(wp2), 32'(5));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
